noc_link_pipe: RTL and testbench

//  Multi-link, per-VC pipelined router-to-router channel for mesh/torus/fmesh NoCs. Inserts STAGES

---
 rtl/noc_link_pkg.sv | 21 ++
 rtl/noc_link_stage.sv | 40 ++++
 rtl/noc_link_pipe.sv | 144 ++++++++++++++
 tb/tb_noc_link_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared definitions for the router-to-router link pipe and the NoC top.
package noc_link_pkg;

  localparam int unsigned LINK_V  = 2;
  localparam int unsigned LINK_FW = 36;
  localparam int unsigned LINK_B  = 4;
  localparam int unsigned LINK_CW = $clog2(LINK_B + 1);

  // One forward transfer on a single link.
  typedef struct packed {
    logic                wr;
    logic [LINK_V-1:0]   vc;
    logic [LINK_FW-1:0]  flit;
  } link_flit_t;

  // True when exactly one bit is set; narrower VC vectors are zero-extended.
  function automatic logic onehot_ok(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/noc_link_stage.sv
// One register slice: a valid bit that always advances and a payload that
// only loads when the incoming valid is set.
module noc_link_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Valid bit follows the input every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
    end
  end

  // Payload holds its value when no transfer is present to save toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (valid_i) begin
      data_q <= data_i;
    end else begin
      data_q <= data_q;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/noc_link_pipe.sv
// Multi-link pipelined channel: STAGES slices forward (flit) and backward
// (credit) per link, plus a per-link/per-VC outstanding-credit monitor.
module noc_link_pipe
  import noc_link_pkg::*;
#(
  parameter int unsigned LINKS  = 4,
  parameter int unsigned V      = LINK_V,
  parameter int unsigned FW     = LINK_FW,
  parameter int unsigned B      = LINK_B,
  parameter int unsigned STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LINKS-1:0]                  in_flit_wr,
  input  logic [LINKS*FW-1:0]               in_flit,
  input  logic [LINKS*V-1:0]                in_vc,
  output logic [LINKS-1:0]                  out_flit_wr,
  output logic [LINKS*FW-1:0]               out_flit,
  output logic [LINKS*V-1:0]                out_vc,
  input  logic [LINKS*V-1:0]                dn_credit_in,
  output logic [LINKS*V-1:0]                up_credit_out,
  output logic [LINKS*V*$clog2(B+1)-1:0]    outstanding,
  output logic [LINKS-1:0]                  err_onehot,
  output logic [LINKS-1:0]                  err_credit,
  input  logic                              err_clr
);

  localparam int unsigned CW = $clog2(B + 1);

  logic [LINKS*V-1:0] viol_s;
  logic [LINKS-1:0]   set_credit_s;
  logic [LINKS-1:0]   set_onehot_s;
  logic [LINKS-1:0]   err_credit_q;
  logic [LINKS-1:0]   err_onehot_q;

  for (genvar i = 0; i < LINKS; i++) begin : g_link
    logic [STAGES:0]   fv_s;
    logic [FW+V-1:0]   fd_s [STAGES+1];
    logic [STAGES:0]   bv_s;
    logic [V-1:0]      bd_s [STAGES+1];

    assign fv_s[0] = in_flit_wr[i];
    assign fd_s[0] = {in_vc[i*V +: V], in_flit[i*FW +: FW]};
    assign bv_s[0] = |dn_credit_in[i*V +: V];
    assign bd_s[0] = dn_credit_in[i*V +: V];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      noc_link_stage #(.W(FW + V)) u_fwd (
        .clk     (clk),
        .rst_n   (reset),
        .valid_i (fv_s[s]),
        .data_i  (fd_s[s]),
        .valid_o (fv_s[s+1]),
        .data_o  (fd_s[s+1])
      );
      noc_link_stage #(.W(V)) u_bwd (
        .clk     (clk),
        .rst_n   (reset),
        .valid_i (bv_s[s]),
        .data_i  (bd_s[s]),
        .valid_o (bv_s[s+1]),
        .data_o  (bd_s[s+1])
      );
    end

    assign out_flit_wr[i]              = fv_s[STAGES];
    assign out_vc[i*V +: V]            = fd_s[STAGES][FW +: V];
    assign out_flit[i*FW +: FW]        = fd_s[STAGES][0 +: FW];
    assign up_credit_out[i*V +: V]     = bv_s[STAGES] ? bd_s[STAGES] : {V{1'b0}};

    for (genvar v = 0; v < V; v++) begin : g_vc
      logic          inc_s;
      logic          dec_s;
      logic          bad_s;
      logic [CW-1:0] cnt_d;
      logic [CW-1:0] cnt_q;

      assign inc_s = in_flit_wr[i] & in_vc[i*V+v];
      assign dec_s = up_credit_out[i*V+v];

      // Saturating up/down count of flits sent but not yet credited back.
      always_comb begin
        cnt_d = cnt_q;
        bad_s = 1'b0;
        case ({inc_s, dec_s})
          2'b10: begin
            if (cnt_q == CW'(B)) begin
              bad_s = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          2'b01: begin
            if (cnt_q == CW'(0)) begin
              bad_s = 1'b1;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end

      // Outstanding-count register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign viol_s[i*V+v]               = bad_s;
      assign outstanding[(i*V+v)*CW +: CW] = cnt_q;
    end
  end

  // Per-link error set conditions: any VC count violation, or a non-one-hot VC on a valid flit.
  always_comb begin
    set_credit_s = '0;
    set_onehot_s = '0;
    for (int unsigned i = 0; i < LINKS; i++) begin
      set_credit_s[i] = |viol_s[i*V +: V];
      set_onehot_s[i] = in_flit_wr[i] & ~onehot_ok(32'(in_vc[i*V +: V]));
    end
  end

  // Sticky error flags; a fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_credit_q <= '0;
      err_onehot_q <= '0;
    end else begin
      err_credit_q <= set_credit_s | (err_credit_q & ~{LINKS{err_clr}});
      err_onehot_q <= set_onehot_s | (err_onehot_q & ~{LINKS{err_clr}});
    end
  end

  assign err_credit = err_credit_q;
  assign err_onehot = err_onehot_q;

endmodule

// File: tb/tb_noc_link_pipe.sv
// Randomised plus directed bench for noc_link_pipe: three instances (STAGES 2, 0, 8)
// share stimulus and are each checked every cycle against a behavioural model.
module tb_noc_link_pipe;

  localparam int ST [3] = '{2, 0, 8};

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   in_flit_wr = '0;
  logic [143:0] in_flit = '0;
  logic [7:0]   in_vc = '0;
  logic [7:0]   dn_credit_in = '0;
  logic         err_clr = 1'b0;

  logic [3:0]   o_wr  [3];
  logic [143:0] o_fl  [3];
  logic [7:0]   o_vc  [3];
  logic [7:0]   o_cr  [3];
  logic [23:0]  o_out [3];
  logic [3:0]   o_eo  [3];
  logic [3:0]   o_ec  [3];

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    noc_link_pipe #(.LINKS(4), .V(2), .FW(36), .B(4), .STAGES(ST[k])) u_dut (
      .clk           (clk),
      .reset         (reset),
      .in_flit_wr    (in_flit_wr),
      .in_flit       (in_flit),
      .in_vc         (in_vc),
      .out_flit_wr   (o_wr[k]),
      .out_flit      (o_fl[k]),
      .out_vc        (o_vc[k]),
      .dn_credit_in  (dn_credit_in),
      .up_credit_out (o_cr[k]),
      .outstanding   (o_out[k]),
      .err_onehot    (o_eo[k]),
      .err_credit    (o_ec[k]),
      .err_clr       (err_clr)
    );
  end

  // ---------------- behavioural model ----------------
  // hX[d] = input seen d clock edges ago (d = 1..8); a pipe of S stages shows hX[S].
  logic [3:0]   hw [0:8];
  logic [143:0] hf [0:8];
  logic [7:0]   hv [0:8];
  logic [7:0]   hc [0:8];
  int           cnt [3][4][2];
  logic [3:0]   ec [3];
  logic [3:0]   eo;

  logic [7:0] m_cr;
  logic       m_new;
  logic       m_inc;
  logic       m_dec;
  int         m_c;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d <= 8; d++) begin
        hw[d] <= '0; hf[d] <= '0; hv[d] <= '0; hc[d] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        ec[k] <= '0;
        for (int i = 0; i < 4; i++) for (int v = 0; v < 2; v++) cnt[k][i][v] <= 0;
      end
      eo <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_cr = (ST[k] == 0) ? dn_credit_in : hc[ST[k]];
        for (int i = 0; i < 4; i++) begin
          m_new = 1'b0;
          for (int v = 0; v < 2; v++) begin
            m_inc = in_flit_wr[i] && in_vc[i*2+v];
            m_dec = m_cr[i*2+v];
            m_c   = cnt[k][i][v];
            if (m_inc && !m_dec) begin
              if (m_c == 4) m_new = 1'b1; else m_c = m_c + 1;
            end else if (!m_inc && m_dec) begin
              if (m_c == 0) m_new = 1'b1; else m_c = m_c - 1;
            end
            cnt[k][i][v] <= m_c;
          end
          ec[k][i] <= m_new | (ec[k][i] & ~err_clr);
        end
      end
      for (int i = 0; i < 4; i++)
        eo[i] <= (in_flit_wr[i] && ($countones(in_vc[i*2 +: 2]) != 1)) | (eo[i] & ~err_clr);
      for (int d = 8; d >= 2; d--) begin
        hw[d] <= hw[d-1]; hf[d] <= hf[d-1]; hv[d] <= hv[d-1]; hc[d] <= hc[d-1];
      end
      hw[1] <= in_flit_wr; hf[1] <= in_flit; hv[1] <= in_vc; hc[1] <= dn_credit_in;
    end
  end

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model, away from the clock edge.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0]   ewr;
        logic [143:0] efl, fmask;
        logic [7:0]   evc, ecr, vmask;
        logic [23:0]  eout;
        ewr = (ST[k] == 0) ? in_flit_wr   : hw[ST[k]];
        efl = (ST[k] == 0) ? in_flit      : hf[ST[k]];
        evc = (ST[k] == 0) ? in_vc        : hv[ST[k]];
        ecr = (ST[k] == 0) ? dn_credit_in : hc[ST[k]];
        fmask = '0; vmask = '0; eout = '0;
        for (int i = 0; i < 4; i++) begin
          if (ewr[i]) begin
            fmask[i*36 +: 36] = {36{1'b1}};
            vmask[i*2 +: 2]   = 2'b11;
          end
          for (int v = 0; v < 2; v++) eout[(i*2+v)*3 +: 3] = 3'(cnt[k][i][v]);
        end
        check($sformatf("s%0d_out_flit_wr", ST[k]), 144'(o_wr[k]), 144'(ewr));
        check($sformatf("s%0d_out_flit", ST[k]), o_fl[k] & fmask, efl & fmask);
        check($sformatf("s%0d_out_vc", ST[k]), 144'(o_vc[k] & vmask), 144'(evc & vmask));
        check($sformatf("s%0d_up_credit", ST[k]), 144'(o_cr[k]), 144'(ecr));
        check($sformatf("s%0d_outstanding", ST[k]), 144'(o_out[k]), 144'(eout));
        check($sformatf("s%0d_err_credit", ST[k]), 144'(o_ec[k]), 144'(ec[k]));
        check($sformatf("s%0d_err_onehot", ST[k]), 144'(o_eo[k]), 144'(eo));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [3:0] wr, input logic [143:0] fl, input logic [7:0] vc,
                     input logic [7:0] cr, input logic clr);
    @(posedge clk);
    #1;
    in_flit_wr = wr; in_flit = fl; in_vc = vc; dn_credit_in = cr; err_clr = clr;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(4'h0, 144'h0, 8'h0, 8'h0, 1'b0);
  endtask

  logic [35:0]  pay;
  logic [143:0] fl;
  logic [3:0]   wr;
  logic [7:0]   vc, cr;
  logic [3:0]   seen;

  initial begin
    pay = 36'h9_ABCD_1234;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k += 2) begin
      check("reset_out_wr", 144'(o_wr[k]), 144'h0);
      check("reset_outstanding", 144'(o_out[k]), 144'h0);
      check("reset_errs", 144'({o_ec[k], o_eo[k], o_cr[k]}), 144'h0);
    end
    @(posedge clk); #1; reset = 1'b1; started = 1'b1;
    idle(2);

    // Single flit on link 0, vc0.
    cyc(4'b0001, 144'(pay), 8'h01, 8'h00, 1'b0);
    #1 check("s0_same_cycle_wr", 144'(o_wr[1]), 144'h1);
    idle(1);
    @(negedge clk);
    check("s2_outstanding_t1", 144'(o_out[0]), 144'h1);
    check("s2_not_yet_out", 144'(o_wr[0]), 144'h0);
    idle(1);
    @(negedge clk);
    check("s2_out_wr_t2", 144'(o_wr[0]), 144'h1);
    check("s2_payload_t2", 144'(o_fl[0][35:0]), 144'(pay));
    cyc(4'h0, 144'h0, 8'h00, 8'h01, 1'b0);
    idle(12);

    // Saturation on link 0 vc0.
    for (int j = 0; j < 5; j++) cyc(4'b0001, 144'($urandom), 8'h01, 8'h00, 1'b0);
    idle(2);
    @(negedge clk);
    check("sat_outstanding", 144'(o_out[0][2:0]), 144'h4);
    check("sat_err_credit", 144'(o_ec[0][0]), 144'h1);
    cyc(4'h0, 144'h0, 8'h00, 8'h00, 1'b1);
    idle(1);
    @(negedge clk);
    check("sat_err_cleared", 144'(o_ec[0][0]), 144'h0);
    for (int j = 0; j < 4; j++) cyc(4'h0, 144'h0, 8'h00, 8'h01, 1'b0);
    idle(12);

    // Underflow: credit on link 2 vc1 with nothing outstanding.
    cyc(4'h0, 144'h0, 8'h00, 8'h20, 1'b0);
    idle(3);
    @(negedge clk);
    check("unf_err_credit", 144'(o_ec[0][2]), 144'h1);
    check("unf_count_zero", 144'(o_out[0][17:12]), 144'h0);
    idle(8);
    cyc(4'h0, 144'h0, 8'h00, 8'h00, 1'b1);

    // Bad one-hot on link 1, then simultaneous clear and new error.
    cyc(4'b0010, 144'($urandom) << 36, 8'h0C, 8'h00, 1'b0);
    idle(1);
    @(negedge clk);
    check("onehot_err_set", 144'(o_eo[0][1]), 144'h1);
    cyc(4'b0010, 144'($urandom) << 36, 8'h0C, 8'h00, 1'b1);
    idle(1);
    @(negedge clk);
    check("onehot_set_beats_clr", 144'(o_eo[0][1]), 144'h1);
    cyc(4'h0, 144'h0, 8'h00, 8'h0C, 1'b1);
    cyc(4'h0, 144'h0, 8'h00, 8'h0C, 1'b0);
    @(negedge clk);
    check("onehot_err_cleared", 144'(o_eo[0][1]), 144'h0);
    idle(12);
    cyc(4'h0, 144'h0, 8'h00, 8'h00, 1'b1);

    // Back-to-back 8 flits on link 3, alternating VC, credits 5 cycles later.
    for (int j = 0; j < 13; j++) begin
      wr = (j < 8) ? 4'b1000 : 4'b0000;
      vc = (j < 8) ? (((j % 2) == 1) ? 8'h80 : 8'h40) : 8'h00;
      cr = (j >= 5) ? ((((j - 5) % 2) == 1) ? 8'h80 : 8'h40) : 8'h00;
      cyc(wr, {36'($urandom), 108'h0}, vc, cr, 1'b0);
    end
    idle(15);
    @(negedge clk);
    check("b2b_count_end", 144'(o_out[0]), 144'h0);
    check("b2b_no_err", 144'(o_ec[0]), 144'h0);

    // Randomised traffic.
    for (int j = 0; j < 400; j++) begin
      for (int i = 0; i < 4; i++) begin
        fl[i*36 +: 36] = {4'($urandom), 32'($urandom)};
        wr[i] = $urandom_range(0, 1) == 1;
        vc[i*2 +: 2] = ($urandom_range(0, 15) == 0) ? 2'($urandom) : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
        cr[i*2 +: 2] = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      end
      cyc(wr, fl, vc, cr, $urandom_range(0, 15) == 0);
    end

    // Reset with two flits in flight.
    idle(12);
    cyc(4'b0001, 144'($urandom), 8'h01, 8'h00, 1'b0);
    cyc(4'b0100, 144'($urandom) << 72, 8'h10, 8'h00, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_flit_wr = '0; in_flit = '0; in_vc = '0; dn_credit_in = '0; err_clr = 1'b0;
    #1;
    check("rst_s2_out_wr", 144'(o_wr[0]), 144'h0);
    check("rst_s8_out_wr", 144'(o_wr[2]), 144'h0);
    check("rst_outstanding", 144'({o_out[0], o_out[2]}), 144'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = '0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      seen = seen | o_wr[0] | o_wr[2];
    end
    check("rst_no_ghost_flit", 144'(seen), 144'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
